id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 15 +
 rtl/id_stage_if.sv | 19 +
 rtl/id_stage_imm_gen.sv | 17 +
 rtl/id_stage.sv | 79 +++++++
 tb/tb_id_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared core constants for the decode stage
package id_stage_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef enum logic [6:0] {
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111
  } opcode_e;
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: decode output register bundle handed to EX with its ready handshake
interface id_stage_if import id_stage_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic            out_regwrite;
  logic            out_is_load;
  modport master(output out_valid, out_pc, out_op1, out_op2, out_imm, out_rd, out_opcode,
                 out_funct3, out_funct7b5, out_regwrite, out_is_load, input out_ready);
  modport slave(input out_valid, out_pc, out_op1, out_op2, out_imm, out_rd, out_opcode,
                out_funct3, out_funct7b5, out_regwrite, out_is_load, output out_ready);
endinterface

// File: rtl/id_stage_imm_gen.sv
// imm_gen: I/S/B/U/J immediate extraction, sign-extended to XLEN
module imm_gen import id_stage_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  logic [6:0]  op;
  logic [31:0] i;
  assign op = instr[6:0];
  always_comb
    i = (op == LOAD || op == OP_IMM || op == JALR) ? {{20{instr[31]}}, instr[31:20]} :
        op == STORE  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
        op == BRANCH ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
        (op == LUI || op == AUIPC) ? {instr[31:12], 12'b0} :
        op == JAL    ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
        32'b0;
  assign imm = XLEN'($signed(i));
endmodule

// File: rtl/id_stage.sv
// id_stage: decode with operand forwarding, load/ALU-use stall, flush and output register
module id_stage import id_stage_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            mem_write,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            mem_is_load,
  input  logic            wb_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  id_stage_if.master      ex
);
  logic [6:0]      op;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm, op1, op2;
  logic            use1, use2, hazard, advance, regw;
  imm_gen #(.XLEN(XLEN)) u_imm (.instr(if_instr), .imm(imm));
  assign op  = if_instr[6:0];
  assign rd  = if_instr[11:7];
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  always_comb begin
    use1 = !(op == LUI || op == AUIPC || op == JAL) && rs1 != 5'd0;
    use2 = (op == OP || op == STORE || op == BRANCH) && rs2 != 5'd0;
    op1 = rs1 == 5'd0 ? '0 : (mem_write && !mem_is_load && mem_rd == rs1) ? mem_result :
          (wb_write && wb_rd == rs1) ? wb_data : rd1;
    op2 = rs2 == 5'd0 ? '0 : (mem_write && !mem_is_load && mem_rd == rs2) ? mem_result :
          (wb_write && wb_rd == rs2) ? wb_data : rd2;
    // a producer still in EX, or a load still in MEM, cannot be forwarded yet
    hazard = (use1 && ((ex.out_valid && ex.out_regwrite && ex.out_rd == rs1) ||
                       (mem_write && mem_is_load && mem_rd == rs1))) ||
             (use2 && ((ex.out_valid && ex.out_regwrite && ex.out_rd == rs2) ||
                       (mem_write && mem_is_load && mem_rd == rs2)));
    regw = (op == OP || op == OP_IMM || op == LOAD || op == LUI || op == AUIPC ||
            op == JAL || op == JALR) && rd != 5'd0;
    advance = !ex.out_valid || ex.out_ready;
    id_ready = flush || (advance && !hazard);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex.out_valid    <= 1'b0;
      ex.out_pc       <= '0;
      ex.out_op1      <= '0;
      ex.out_op2      <= '0;
      ex.out_imm      <= '0;
      ex.out_rd       <= '0;
      ex.out_opcode   <= '0;
      ex.out_funct3   <= '0;
      ex.out_funct7b5 <= 1'b0;
      ex.out_regwrite <= 1'b0;
      ex.out_is_load  <= 1'b0;
    end else if (flush || (advance && hazard)) begin
      ex.out_valid    <= 1'b0;
      ex.out_regwrite <= 1'b0;
      ex.out_is_load  <= 1'b0;
    end else if (advance) begin
      ex.out_valid    <= if_valid;
      ex.out_pc       <= if_pc;
      ex.out_op1      <= op1;
      ex.out_op2      <= op2;
      ex.out_imm      <= imm;
      ex.out_rd       <= rd;
      ex.out_opcode   <= op;
      ex.out_funct3   <= if_instr[14:12];
      ex.out_funct7b5 <= if_instr[30];
      ex.out_regwrite <= if_valid && regw;
      ex.out_is_load  <= if_valid && op == LOAD;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table plus hand-written stall/hold/flush/reset sequences
module tb_id_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        if_valid = 1'b0, id_ready;
  logic [31:0] if_instr = '0, if_pc = '0;
  logic [4:0]  rs1, rs2;
  logic [31:0] rd1 = '0, rd2 = '0;
  logic        mem_write = 1'b0, mem_is_load = 1'b0, wb_write = 1'b0, flush = 1'b0;
  logic [4:0]  mem_rd = '0, wb_rd = '0;
  logic [31:0] mem_result = '0, wb_data = '0;
  int          n_chk = 0, n_fail = 0;

  id_stage_if #(.XLEN(32)) ex();

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
    .mem_write(mem_write), .mem_rd(mem_rd), .mem_result(mem_result), .mem_is_load(mem_is_load),
    .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex(ex)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI1 = 32'h00500093, ADD3 = 32'h002081B3, LW5 = 32'h00002283,
                          ADD6 = 32'h00028333, LUI2 = 32'h12345137;

  typedef struct {
    logic [31:0] instr, imm, op1, op2;
    logic [4:0]  rd;
    logic        rw, ld;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  task automatic quiet();
    mem_write = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
    wb_write = 0; wb_rd = 0; wb_data = 0; flush = 0; ex.out_ready = 1;
    put(0, 32'h0, 32'h0);
  endtask

  initial begin
    tv[0]  = '{32'h00500093, 32'h00000005, 32'h0,  32'h22, 5'd1,  1, 0};
    tv[1]  = '{32'h002081B3, 32'h00000000, 32'h11, 32'h22, 5'd3,  1, 0};
    tv[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 32'h0,  32'h0,  5'd29, 0, 0};
    tv[3]  = '{32'h0000006F, 32'h00000000, 32'h0,  32'h0,  5'd0,  0, 0};
    tv[4]  = '{32'h008000EF, 32'h00000008, 32'h0,  32'h22, 5'd1,  1, 0};
    tv[5]  = '{32'h12345137, 32'h12345000, 32'h11, 32'h22, 5'd2,  1, 0};
    tv[6]  = '{32'hFE20AC23, 32'hFFFFFFF8, 32'h11, 32'h22, 5'd24, 0, 0};
    tv[7]  = '{32'h00002283, 32'h00000000, 32'h0,  32'h0,  5'd5,  1, 1};
    tv[8]  = '{32'hFFF00213, 32'hFFFFFFFF, 32'h0,  32'h22, 5'd4,  1, 0};
    tv[9]  = '{32'hFFFFF397, 32'hFFFFF000, 32'h11, 32'h22, 5'd7,  1, 0};
    tv[10] = '{32'h0000000F, 32'h00000000, 32'h0,  32'h0,  5'd0,  0, 0};
    tv[11] = '{32'h000080E7, 32'h00000000, 32'h11, 32'h0,  5'd1,  1, 0};
    ex.out_ready = 1;
    step();
    step();
    chk("rst_valid", ex.out_valid, 0);
    chk("rst_pc", ex.out_pc, 0);
    chk("rst_op1", ex.out_op1, 0);
    chk("rst_op2", ex.out_op2, 0);
    chk("rst_imm", ex.out_imm, 0);
    chk("rst_rd", ex.out_rd, 0);
    chk("rst_opcode", ex.out_opcode, 0);
    chk("rst_regwrite", ex.out_regwrite, 0);
    chk("rst_is_load", ex.out_is_load, 0);
    reset = 0;
    rd1 = 32'h11;
    rd2 = 32'h22;
    for (int i = 0; i < 12; i++) begin
      put(1, tv[i].instr, 32'h100 + 32'(i) * 4);
      #1 chk($sformatf("v%0d_ready", i), id_ready, 1);
      step();
      chk($sformatf("v%0d_valid", i), ex.out_valid, 1);
      chk($sformatf("v%0d_pc", i), ex.out_pc, 32'h100 + 32'(i) * 4);
      chk($sformatf("v%0d_imm", i), ex.out_imm, tv[i].imm);
      chk($sformatf("v%0d_op1", i), ex.out_op1, tv[i].op1);
      chk($sformatf("v%0d_op2", i), ex.out_op2, tv[i].op2);
      chk($sformatf("v%0d_rd", i), ex.out_rd, tv[i].rd);
      chk($sformatf("v%0d_regwrite", i), ex.out_regwrite, tv[i].rw);
      chk($sformatf("v%0d_is_load", i), ex.out_is_load, tv[i].ld);
      put(0, 32'h0, 32'h0);
      step();
      chk($sformatf("v%0d_idle", i), ex.out_valid, 0);
    end
    // forwarding priority: MEM over WB over register file
    quiet();
    rd1 = 0; rd2 = 0;
    put(1, ADD3, 32'h700);
    mem_write = 1; mem_rd = 1; mem_result = 7;
    wb_write = 1; wb_rd = 2; wb_data = 9;
    step();
    chk("fwd_op1", ex.out_op1, 7);
    chk("fwd_op2", ex.out_op2, 9);
    put(1, ADD3, 32'h704);
    mem_rd = 2; wb_rd = 2; rd1 = 32'h33;
    step();
    chk("fwd_pri_op1", ex.out_op1, 32'h33);
    chk("fwd_pri_op2", ex.out_op2, 7);
    // ALU producer: one stall cycle, then MEM forward
    quiet(); step();
    rd1 = 32'h11; rd2 = 32'h22;
    put(1, ADDI1, 32'h600);
    step();
    put(1, ADD3, 32'h604);
    #1 chk("alu_ready0", id_ready, 0);
    step();
    chk("alu_bubble", ex.out_valid, 0);
    mem_write = 1; mem_rd = 1; mem_result = 32'h77;
    #1 chk("alu_ready1", id_ready, 1);
    step();
    chk("alu_valid", ex.out_valid, 1);
    chk("alu_pc", ex.out_pc, 32'h604);
    chk("alu_op1", ex.out_op1, 32'h77);
    chk("alu_op2", ex.out_op2, 32'h22);
    // load-use: two stall cycles, then WB forward
    quiet(); step();
    put(1, LW5, 32'h200);
    step();
    put(1, ADD6, 32'h204);
    #1 chk("lu_ready0", id_ready, 0);
    step();
    chk("lu_bubble0", ex.out_valid, 0);
    chk("lu_bubble0_rw", ex.out_regwrite, 0);
    mem_write = 1; mem_rd = 5; mem_is_load = 1;
    #1 chk("lu_ready1", id_ready, 0);
    step();
    chk("lu_bubble1", ex.out_valid, 0);
    mem_write = 0; mem_is_load = 0;
    wb_write = 1; wb_rd = 5; wb_data = 32'h55; rd1 = 32'h99;
    #1 chk("lu_ready2", id_ready, 1);
    step();
    chk("lu_valid", ex.out_valid, 1);
    chk("lu_pc", ex.out_pc, 32'h204);
    chk("lu_op1", ex.out_op1, 32'h55);
    chk("lu_rd", ex.out_rd, 6);
    // EX back-pressure: hold for three cycles
    quiet(); step();
    put(1, ADDI1, 32'h500);
    step();
    ex.out_ready = 0;
    put(1, LUI2, 32'h504);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("hold%0d_ready", k), id_ready, 0);
      step();
      chk($sformatf("hold%0d_valid", k), ex.out_valid, 1);
      chk($sformatf("hold%0d_pc", k), ex.out_pc, 32'h500);
      chk($sformatf("hold%0d_imm", k), ex.out_imm, 5);
    end
    ex.out_ready = 1;
    #1 chk("hold_release_ready", id_ready, 1);
    step();
    chk("hold_release_pc", ex.out_pc, 32'h504);
    chk("hold_release_imm", ex.out_imm, 32'h12345000);
    // flush during a load-use stall
    quiet(); step();
    put(1, LW5, 32'h300);
    step();
    put(1, ADD6, 32'h304);
    #1 chk("fl_stall", id_ready, 0);
    flush = 1;
    #1 chk("fl_ready", id_ready, 1);
    step();
    chk("fl_valid", ex.out_valid, 0);
    chk("fl_regwrite", ex.out_regwrite, 0);
    chk("fl_is_load", ex.out_is_load, 0);
    // flush while EX holds the output
    quiet(); step();
    put(1, ADDI1, 32'h400);
    step();
    ex.out_ready = 0;
    put(1, LUI2, 32'h404);
    flush = 1;
    step();
    chk("flh_valid", ex.out_valid, 0);
    flush = 0;
    step();
    chk("flh_capture", ex.out_pc, 32'h404);
    // asynchronous reset in the middle of a stall
    quiet(); step();
    put(1, LW5, 32'h800);
    step();
    put(1, ADD6, 32'h804);
    #1 chk("rs_stall", id_ready, 0);
    reset = 1;
    #1 chk("rs_async_valid", ex.out_valid, 0);
    chk("rs_async_pc", ex.out_pc, 0);
    chk("rs_async_load", ex.out_is_load, 0);
    reset = 0;
    #1 chk("rs_ready", id_ready, 1);
    step();
    chk("rs_capture_valid", ex.out_valid, 1);
    chk("rs_capture_pc", ex.out_pc, 32'h804);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
